// File: rtl/driver_fifo_interface.sv
// Avalon-ST sink that buffers audio samples in a FIFO, drained by software through
// a 4-register Avalon-MM slave, with a level-threshold interrupt.
module driver_fifo_interface #(
    parameter int DATA_SIZE  = 28,
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 8,
    parameter int SIGN_EXT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          read_data,
    input  logic                 source_valid,
    input  logic [DATA_SIZE-1:0] source_data,
    output logic                 source_ready,
    output logic                 irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_RST = LW'(IRQ_THRESH);

    function automatic logic [31:0] extend_sample(input logic [DATA_SIZE-1:0] s);
        logic [31:0] r;
        if (SIGN_EXT != 0) begin
            r = 32'($signed(s));
        end else begin
            r = 32'(s);
        end
        return r;
    endfunction

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, thresh_q, thresh_d, thresh_wr_s;
    logic [31:0]   read_data_q, read_data_d, status_s, control_s;
    logic          underflow_q, underflow_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic          rd_s, wr_s, push_s, pop_s, flush_s, empty_s, full_s;
    logic          unused_wd_s;

    assign rd_s         = chipselect && read;
    assign wr_s         = chipselect && write && !read;
    assign empty_s      = (level_q == {LW{1'b0}});
    assign full_s       = (level_q == DEPTH_L);
    assign source_ready = !rst && !full_s;
    assign push_s       = source_valid && source_ready;
    assign pop_s        = rd_s && (address == 2'd0) && !empty_s;
    assign flush_s      = wr_s && (address == 2'd3) && writedata[1];
    assign thresh_wr_s  = writedata[16 +: LW];
    assign unused_wd_s  = ^{writedata[31:16+LW], writedata[15:2]};
    assign read_data    = read_data_q;
    assign irq          = irq_q;

    // Sample storage; contents survive reset and flush, only pointers move.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= source_data;
        end
    end

    // Pointer and level bookkeeping; flush overrides a concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                level_d = level_q + LW'(1'b1);
            end else if (pop_s && !push_s) begin
                level_d = level_q - LW'(1'b1);
            end else begin
                level_d = level_q;
            end
        end
    end

    // Register map: read mux, control/command writes and interrupt level.
    always_comb begin
        status_s = 32'd0;
        status_s[LW-1:0] = level_q;
        status_s[16] = empty_s;
        status_s[17] = full_s;
        status_s[18] = underflow_q;
        status_s[19] = irq_q;
        control_s = 32'd0;
        control_s[0] = irq_en_q;
        control_s[16 +: LW] = thresh_q;

        read_data_d = read_data_q;
        underflow_d = underflow_q;
        irq_en_d    = irq_en_q;
        thresh_d    = thresh_q;
        if (rd_s) begin
            case (address)
                2'd0:    read_data_d = empty_s ? 32'd0 : extend_sample(mem_q[rd_ptr_q]);
                2'd1:    read_data_d = status_s;
                2'd2:    read_data_d = control_s;
                default: read_data_d = 32'd0;
            endcase
        end else begin
            read_data_d = read_data_q;
        end
        if (wr_s && (address == 2'd2)) begin
            irq_en_d = writedata[0];
            thresh_d = (thresh_wr_s > DEPTH_L) ? DEPTH_L : thresh_wr_s;
        end else begin
            irq_en_d = irq_en_q;
            thresh_d = thresh_q;
        end
        // Clear first so that a simultaneous new underflow takes precedence.
        if (wr_s && (address == 2'd3) && writedata[0]) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
        if (rd_s && (address == 2'd0) && empty_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_d;
        end
        irq_d = irq_en_q && (thresh_q != {LW{1'b0}}) && (level_d >= thresh_q)
                && (level_d != {LW{1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            read_data_q <= 32'd0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
            thresh_q    <= THRESH_RST;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            read_data_q <= read_data_d;
            underflow_q <= underflow_d;
            irq_en_q    <= irq_en_d;
            thresh_q    <= thresh_d;
            irq_q       <= irq_d;
        end
    end
endmodule

// File: tb/tb_driver_fifo_interface.sv
// Scoreboard bench for driver_fifo_interface: a queue-based reference model predicts
// read responses, ready and irq; zero- and sign-extending instances share stimulus.
module tb_driver_fifo_interface;
    localparam int DS    = 28;
    localparam int DEPTH = 16;
    localparam int THR   = 8;

    logic          clk = 1'b0;
    logic          rst, chipselect, read, write, source_valid;
    logic [1:0]    address;
    logic [31:0]   writedata;
    logic [DS-1:0] source_data;
    logic [31:0]   rdata0, rdata1;
    logic          ready0, ready1, irq0, irq1;

    always #5 clk = ~clk;

    driver_fifo_interface #(.DATA_SIZE(DS), .DEPTH(DEPTH), .IRQ_THRESH(THR), .SIGN_EXT(0)) dut0 (
        .clk(clk), .rst(rst), .chipselect(chipselect), .address(address), .read(read),
        .write(write), .writedata(writedata), .read_data(rdata0), .source_valid(source_valid),
        .source_data(source_data), .source_ready(ready0), .irq(irq0));

    driver_fifo_interface #(.DATA_SIZE(DS), .DEPTH(DEPTH), .IRQ_THRESH(THR), .SIGN_EXT(1)) dut1 (
        .clk(clk), .rst(rst), .chipselect(chipselect), .address(address), .read(read),
        .write(write), .writedata(writedata), .read_data(rdata1), .source_valid(source_valid),
        .source_data(source_data), .source_ready(ready1), .irq(irq1));

    int n_checks = 0;
    int n_fail   = 0;

    logic [DS-1:0] m_fifo[$];
    logic [31:0]   exp0_q[$];
    logic [31:0]   exp1_q[$];
    bit            m_irq_en, m_irq, m_und, m_acc;
    int            m_thresh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [DS-1:0] s, input bit sx);
        logic [31:0] r;
        r = 32'(s);
        if (sx && s[DS-1]) r = r | ~((32'd1 << DS) - 32'd1);
        return r;
    endfunction

    // Reference model: one call per clock edge, using the inputs about to be sampled.
    task automatic model_step();
        bit rd, wr;
        int lvl, nt;
        logic [31:0] v;
        m_acc = 1'b0;
        if (rst) begin
            m_fifo.delete();
            m_irq_en = 1'b0; m_irq = 1'b0; m_und = 1'b0; m_thresh = THR;
            return;
        end
        rd  = chipselect && read;
        wr  = chipselect && write && !read;
        lvl = m_fifo.size();
        if (rd) begin
            case (address)
                2'd0: begin
                    if (lvl > 0) begin
                        exp0_q.push_back(ext(m_fifo[0], 1'b0));
                        exp1_q.push_back(ext(m_fifo[0], 1'b1));
                    end else begin
                        exp0_q.push_back(32'd0);
                        exp1_q.push_back(32'd0);
                    end
                end
                2'd1: begin
                    v = 32'(lvl) | ((lvl == 0) ? 32'h0001_0000 : 32'd0)
                        | ((lvl == DEPTH) ? 32'h0002_0000 : 32'd0)
                        | (m_und ? 32'h0004_0000 : 32'd0) | (m_irq ? 32'h0008_0000 : 32'd0);
                    exp0_q.push_back(v); exp1_q.push_back(v);
                end
                2'd2: begin
                    v = (32'(m_thresh) << 16) | (m_irq_en ? 32'd1 : 32'd0);
                    exp0_q.push_back(v); exp1_q.push_back(v);
                end
                default: begin
                    exp0_q.push_back(32'd0); exp1_q.push_back(32'd0);
                end
            endcase
        end
        if (wr && address == 2'd3 && writedata[0]) m_und = 1'b0;
        if (rd && address == 2'd0) begin
            if (lvl > 0) void'(m_fifo.pop_front());
            else m_und = 1'b1;
        end
        m_acc = source_valid && (lvl != DEPTH);
        if (m_acc) m_fifo.push_back(source_data);
        if (wr && address == 2'd3 && writedata[1]) m_fifo.delete();
        m_irq = m_irq_en && (m_thresh != 0) && (m_fifo.size() >= m_thresh) && (m_fifo.size() != 0);
        if (wr && address == 2'd2) begin
            m_irq_en = writedata[0];
            nt = int'(writedata[20:16]);
            m_thresh = (nt > DEPTH) ? DEPTH : nt;
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        bit rdy;
        #1;
        rdy = !rst && (m_fifo.size() != DEPTH);
        chk("source_ready", {30'd0, ready1, ready0}, {30'd0, rdy, rdy});
        chk("irq", {30'd0, irq1, irq0}, {30'd0, m_irq, m_irq});
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input bit cs, input bit r, input bit w, input logic [1:0] a,
                       input logic [31:0] wd);
        chipselect = cs; read = r; write = w; address = a; writedata = wd;
    endtask

    // Monitor: compares read_data after every edge against the scoreboard.
    initial begin
        logic [31:0] last0, last1, e0, e1;
        int kind;
        last0 = 32'd0; last1 = 32'd0;
        forever begin
            @(posedge clk);
            kind = rst ? 2 : ((chipselect && read) ? 1 : 0);
            @(negedge clk);
            if (kind == 2) begin
                last0 = 32'd0; last1 = 32'd0;
                chk("read_data reset", rdata0, 32'd0);
                chk("read_data reset sext", rdata1, 32'd0);
            end else if (kind == 1) begin
                if (exp0_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard: read response with no expected entry at %0t", $time);
                end else begin
                    e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
                    chk("read_data", rdata0, e0);
                    chk("read_data sext", rdata1, e1);
                    last0 = e0; last1 = e1;
                end
            end else begin
                chk("read_data hold", rdata0, last0);
                chk("read_data hold sext", rdata1, last1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b1; source_valid = 1'b0; source_data = '0;
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        m_irq_en = 1'b0; m_irq = 1'b0; m_und = 1'b0; m_thresh = THR;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Basic push and read, zero and sign extension
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status after reset", rdata0, 32'h0001_0000);
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1; source_data = 28'h1234567; tick(); source_valid = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        chk("data zext", rdata0, 32'h0123_4567);
        chk("data positive sext", rdata1, 32'h0123_4567);
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status empty", rdata0, 32'h0001_0000);
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1; source_data = 28'h9876543; tick(); source_valid = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        chk("data negative zext", rdata0, 32'h0987_6543);
        chk("data negative sext", rdata1, 32'hF987_6543);

        // Fill to full with 17 samples; the 17th must be held
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1; k = 1;
        repeat (17) begin
            source_data = DS'(k); tick();
            if (m_acc) k++;
        end
        chk("ready low when full", {31'd0, ready0}, 32'd0);
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status full", rdata0, 32'h0002_0010);
        bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        chk("first out", rdata0, 32'd1);
        chk("ready after pop", {31'd0, ready0}, 32'd1);
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0); tick();
        source_valid = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
            chk("drain order", rdata0, 32'(i));
        end

        // Underflow set and clear
        bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        chk("empty read", rdata0, 32'd0);
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status underflow", rdata0, 32'h0005_0000);
        bus(1'b1, 1'b0, 1'b1, 2'd3, 32'h1); tick();
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status underflow cleared", rdata0, 32'h0001_0000);

        // Threshold interrupt
        bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0004_0001); tick();
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            source_data = DS'($urandom); tick();
            chk("irq during fill", {31'd0, irq0}, (i == 3) ? 32'd1 : 32'd0);
        end
        source_valid = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        chk("irq falls after pop", {31'd0, irq0}, 32'd0);
        bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0004_0000); tick();
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1;
        repeat (4) begin source_data = DS'($urandom); tick(); end
        source_valid = 1'b0;
        chk("irq disabled", {31'd0, irq0}, 32'd0);
        bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h001F_0001); tick();
        bus(1'b1, 1'b1, 1'b0, 2'd2, 32'd0); tick();
        chk("thresh saturates", rdata0, 32'h0010_0001);
        bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_0001); tick();
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0); tick();
        chk("thresh zero silent", {31'd0, irq0}, 32'd0);
        source_valid = 1'b1; source_data = DS'($urandom);
        bus(1'b1, 1'b0, 1'b1, 2'd3, 32'h2); tick();
        source_valid = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("flush beats push", rdata0, 32'h0001_0000);

        // Level-1 streaming, then reset mid-stream
        bus(1'b1, 1'b0, 1'b1, 2'd2, 32'h0002_0001); tick();
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        source_valid = 1'b1; source_data = DS'($urandom); tick();
        repeat (20) begin
            source_data = DS'($urandom);
            bus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0); tick();
        end
        source_data = DS'($urandom);
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("stream level", rdata0, 32'h0000_0001);
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (3) begin source_data = DS'($urandom); tick(); end
        chk("irq at level 5", {31'd0, irq0}, 32'd1);
        rst = 1'b1; tick();
        chk("reset read_data", rdata0, 32'd0);
        chk("reset irq", {31'd0, irq0}, 32'd0);
        chk("ready low in reset", {31'd0, ready0}, 32'd0);
        rst = 1'b0; source_valid = 1'b0;
        #1 chk("ready after reset", {31'd0, ready0}, 32'd1);
        bus(1'b1, 1'b1, 1'b0, 2'd2, 32'd0); tick();
        chk("control after reset", rdata0, 32'h0008_0000);
        bus(1'b1, 1'b1, 1'b0, 2'd1, 32'd0); tick();
        chk("status after mid reset", rdata0, 32'h0001_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            source_valid = ($urandom_range(0, 99) < (((i / 400) % 2 == 0) ? 80 : 30));
            source_data = DS'($urandom);
            bus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), $urandom);
            if (address == 2'd0 && $urandom_range(0, 1) == 1) read = 1'b1;
            if (address == 2'd3) writedata[1] = ($urandom_range(0, 15) == 0);
            tick();
        end

        rst = 1'b0; source_valid = 1'b0;
        bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        tick(); tick();
        chk("scoreboard drained", 32'(exp0_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
